// File: rtl/tick_generator.sv
// tick_generator: NUM_CH programmable tick strobes and optional divided clocks (macro TICKGEN_CLKOUT_EN)
module tick_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 28,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{28'd50_000_000}},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);
  logic [NUM_CH-1:0] pend;
  logic ch_ok;
  assign ch_ok = int'(cfg_ch) < NUM_CH;
  assign cfg_ready = ch_ok ? ~pend[cfg_ch] : 1'b1;
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : gen_ch
      logic [CNT_W-1:0] cnt, div, pdiv, last;
      logic p, t, term, xfer;
      assign last = (div == '0) ? '0 : div - 1'b1;
      assign term = cnt == last;
      assign xfer = cfg_valid && cfg_ready && ch_ok && (cfg_ch == CH_W'(g));
      assign pend[g] = p;
      assign tick[g] = t;
      // counter, divisor double-buffer and tick strobe
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cnt <= '0;
          div <= DIV_INIT[g*CNT_W +: CNT_W];
          pdiv <= '0;
          p <= 1'b0;
          t <= 1'b0;
        end else if (sync_clr) begin
          cnt <= '0;
          t <= 1'b0;
          div <= xfer ? cfg_div : p ? pdiv : div;
          p <= 1'b0;
        end else begin
          t <= en[g] && term;
          cnt <= en[g] ? (term ? '0 : cnt + 1'b1) : (p ? '0 : cnt);
          div <= (p && (!en[g] || term)) ? pdiv : div;
          p <= xfer || (p && en[g] && !term);
          pdiv <= xfer ? cfg_div : pdiv;
        end
`ifdef TICKGEN_CLKOUT_EN
      logic co;
      assign clk_out[g] = co;
      // divided clock toggles on every terminal count, restarts high
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) co <= 1'b1;
        else if (sync_clr) co <= 1'b1;
        else if (en[g] && term) co <= ~co;
`else
      assign clk_out[g] = 1'b1;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: table vectors, corner sequences and random stimulus against a countdown model
module tb_tick_generator;
  logic clk = 0, rst_n = 0, clr = 0, v = 0, ch = 0, rdy;
  logic [1:0] en = 0, tick, clk_out;
  logic [7:0] cd = 0;
  logic clr3 = 0, rdy3;
  logic [2:0] tick3, co3;
  int checks = 0, errors = 0;
  int m_div [2], m_pdiv [2], m_left [2];
  bit m_pend [2];
  logic [1:0] m_tick, m_clk;
  typedef struct {logic [1:0] tk; logic [1:0] co;} vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  tick_generator #(.NUM_CH(2), .CNT_W(8), .DIV_INIT({8'd3, 8'd5})) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(clr), .cfg_valid(v), .cfg_ready(rdy),
    .cfg_ch(ch), .cfg_div(cd), .tick(tick), .clk_out(clk_out));

  tick_generator #(.NUM_CH(3), .CNT_W(8), .DIV_INIT({3{8'd2}})) dut3 (
    .clk(clk), .rst_n(rst_n), .en(3'b111), .sync_clr(clr3), .cfg_valid(1'b1), .cfg_ready(rdy3),
    .cfg_ch(2'd3), .cfg_div(8'd1), .tick(tick3), .clk_out(co3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int eff(input int d);
    return d == 0 ? 1 : d;
  endfunction

  function automatic bit m_ready(input int c);
    return c >= 2 ? 1'b1 : !m_pend[c];
  endfunction

  function automatic logic [1:0] exp_clk();
`ifdef TICKGEN_CLKOUT_EN
    return m_clk;
`else
    return 2'b11;
`endif
  endfunction

  task automatic m_reset();
    m_div[0] = 5;
    m_div[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0;
      m_pdiv[i] = 0;
      m_left[i] = eff(m_div[i]);
    end
    m_tick = 0;
    m_clk = 2'b11;
  endtask

  task automatic m_edge();
    bit x [2];
    for (int i = 0; i < 2; i++) x[i] = v && m_ready(int'(ch)) && (int'(ch) == i);
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        if (x[i]) m_div[i] = int'(cd);
        else if (m_pend[i]) m_div[i] = m_pdiv[i];
        m_pend[i] = 0;
        m_left[i] = eff(m_div[i]);
        m_tick[i] = 0;
        m_clk[i] = 1;
      end else begin
        m_tick[i] = 0;
        if (en[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_tick[i] = 1;
            m_clk[i] = ~m_clk[i];
            if (m_pend[i]) begin
              m_div[i] = m_pdiv[i];
              m_pend[i] = 0;
            end
            m_left[i] = eff(m_div[i]);
          end
        end else if (m_pend[i]) begin
          m_div[i] = m_pdiv[i];
          m_pend[i] = 0;
          m_left[i] = eff(m_div[i]);
        end
        if (x[i]) begin
          m_pend[i] = 1;
          m_pdiv[i] = int'(cd);
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] e, input logic c, input logic vv, input logic chh, input logic [7:0] d);
    en = e;
    clr = c;
    v = vv;
    ch = chh;
    cd = d;
    #1 chk("cfg_ready", 32'(rdy), 32'(m_ready(int'(ch))));
    @(posedge clk);
    m_edge();
    #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("clk_out", 32'(clk_out), 32'(exp_clk()));
  endtask

  initial begin
    int n;
    tbl[0] = '{2'b00, 2'b11}; tbl[1] = '{2'b00, 2'b11}; tbl[2] = '{2'b10, 2'b01};
    tbl[3] = '{2'b00, 2'b01}; tbl[4] = '{2'b01, 2'b00}; tbl[5] = '{2'b10, 2'b10};
    tbl[6] = '{2'b00, 2'b10}; tbl[7] = '{2'b00, 2'b10}; tbl[8] = '{2'b10, 2'b00};
    tbl[9] = '{2'b01, 2'b01};
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tick", 32'(tick), 0);
    chk("reset_clk_out", 32'(clk_out), 32'(2'b11));
    chk("reset_ready", 32'(rdy), 1);
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 0, 0, 0, 0);
      chk("tbl_tick", 32'(tick), 32'(tbl[k].tk));
`ifdef TICKGEN_CLKOUT_EN
      chk("tbl_clk_out", 32'(clk_out), 32'(tbl[k].co));
`else
      chk("tbl_clk_out", 32'(clk_out), 32'(2'b11));
`endif
    end
    step(2'b11, 0, 1, 0, 8'd2);
    step(2'b11, 0, 1, 0, 8'd7);
    chk("cfg_stall", 32'(rdy), 0);
    repeat (10) step(2'b11, 0, 0, 0, 0);
    step(2'b11, 0, 1, 1, 8'd0);
    repeat (8) step(2'b11, 0, 0, 0, 0);
    step(2'b11, 0, 1, 1, 8'd4);
    step(2'b01, 0, 0, 0, 0);
    step(2'b01, 0, 1, 1, 8'd3);
    repeat (2) step(2'b01, 0, 0, 0, 0);
    repeat (10) step(2'b11, 0, 0, 0, 0);
    n = 0;
    while (m_left[0] != 1 && n < 20) begin
      step(2'b11, 0, 0, 0, 0);
      n++;
    end
    chk("clr_align_bound", 32'(m_left[0]), 1);
    step(2'b11, 1, 0, 0, 0);
    chk("clr_tick", 32'(tick), 0);
    repeat (6) step(2'b11, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_tick", 32'(tick), 0);
    chk("async_clk_out", 32'(clk_out), 32'(2'b11));
    chk("async_ready", 32'(rdy), 1);
    m_reset();
    #1 rst_n = 1;
    repeat (12) step(2'b11, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++)
      step(($urandom % 8 == 0) ? 2'($urandom) : 2'b11, ($urandom % 40) == 0,
           ($urandom % 4) == 0, 1'($urandom), 8'($urandom % 6));
    en = 2'b11;
    clr = 0;
    v = 0;
    clr3 = 1;
    @(posedge clk);
    #1 clr3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk("oor_tick", 32'(tick3), (k % 2 == 0) ? 32'(3'b111) : 0);
      chk("oor_ready", 32'(rdy3), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
